seq_shifter: RTL and testbench
==============================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter: WIDTH, default 32, data width in bits; SHALL be >= 2.
REQ-002 Parameter: SHAMT_W, default 5, shift-amount width; SHALL equal clog2(WIDTH).
REQ-003 Port: clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_i  input  1  asynchronous, active-low reset.
REQ-005 Port: start_i  input  1  request; sampled on a rising edge in IDLE or DONE.
REQ-006 Port: data_i  input  WIDTH  operand; latched when start is accepted.
REQ-007 Port: shamt_i  input  SHAMT_W  shift amount, unsigned; latched when start is accepted.
REQ-008 Port: mode_i  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROL; latched when start is accepted.
REQ-009 Port: busy_o  output  1  high while in SHIFT.
REQ-010 Port: done_o  output  1  high for exactly one cycle while in DONE.
REQ-011 Port: data_o  output  WIDTH  result register; valid while done_o is high; held until the next accepted start.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE; there SHALL be no other reachable state.
REQ-013 Start is accepted when start_i=1 on a rising edge in IDLE or DONE.
- data_i is loaded into the result register.
- shamt_i is loaded into the counter and mode_i is latched.
- Next state is SHIFT if shamt_i!=0, else DONE.
REQ-014 On each rising edge in SHIFT, the result register SHALL shift by exactly one bit and the counter SHALL decrement by 1; when the counter equals 1, the next state SHALL be DONE.
REQ-015 Per-bit shift rules:
- SLL: insert 0 at the LSB.
- SRL: insert 0 at the MSB.
- SRA: replicate the MSB.
- ROL: move the old MSB into the LSB.
REQ-016 Latency: done_o SHALL assert exactly shamt+1 cycles after the accepting edge, for all shamt values 0..WIDTH-1.
REQ-017 In DONE without start_i, the next state SHALL be IDLE; with start_i, a new operation SHALL begin (back-to-back, no idle cycle).
REQ-018 start_i SHALL be ignored in SHIFT; latched operands SHALL NOT change mid-operation.
REQ-019 Changes on data_i, shamt_i or mode_i outside the accepting edge SHALL have no effect.
REQ-020 busy_o and done_o SHALL be decoded from state only and SHALL never be high together.

Reset
REQ-021 When rst_i=0, the block SHALL enter IDLE immediately, regardless of the clock, from any state including mid-SHIFT.
REQ-022 Reset values:
- busy_o=0, done_o=0.
- data_o=0, counter=0, latched mode=00.
REQ-023 After rst_i deasserts, the first start SHALL be accepted on the next rising edge with start_i=1.

Configuration
REQ-024 Macro SEQ_SHIFTER_ROTATE_EN:
- When defined, mode 11 SHALL perform ROL per REQ-015.
- When undefined, the rotate logic SHALL be absent and mode 11 SHALL behave exactly as SLL.

Verification
REQ-025 SLL: data_i=0x00000001, shamt=2, mode=00 -> done_o at cycle 3, data_o=0x00000004; busy_o high in cycles 1-2.
REQ-026 SRA: data_i=0x80000000, shamt=4, mode=10 -> done_o at cycle 5, data_o=0xF8000000. SRL with the same operands -> 0x08000000.
REQ-027 ROL: data_i=0x80000001, shamt=1, mode=11 -> data_o=0x00000003 with SEQ_SHIFTER_ROTATE_EN defined; 0x00000002 without it.
REQ-028 Zero shift: shamt=0, data_i=0xDEADBEEF -> done_o at cycle 1, data_o=0xDEADBEEF, busy_o never high.
REQ-029 Start ignored while busy: start shamt=31 on data_i=0x00000001, then pulse start_i with other operands during SHIFT -> done_o at cycle 32 only, data_o=0x80000000.
REQ-030 Reset mid-operation: start shamt=10, assert rst_i=0 at cycle 4 -> busy_o, done_o and data_o go to 0 without a clock edge; no done_o pulse follows. Back-to-back: start_i held during DONE -> next operation starts with no IDLE cycle.

Source files
------------

// File: rtl/seq_shifter.sv
// ============================================================================
// Module   : seq_shifter
// Purpose  : Multi-cycle barrel-free shifter (SLL/SRL/SRA/ROL), one bit per
//            clock, sequenced by an IDLE/SHIFT/DONE FSM.
//            Optional macro SEQ_SHIFTER_ROTATE_EN enables ROL on mode 11;
//            without it mode 11 behaves as SLL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         mode_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   data_o
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   shifted;
    logic [SHAMT_W-1:0] count;
    logic [1:0]         mode_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are pure state decodes, so busy and done are mutually exclusive.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    accept     = 1'b1;
                    state_next = (shamt_i != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                busy_o = 1'b1;
                if (count == SHAMT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o = 1'b1;
                if (start_i) begin
                    accept     = 1'b1;
                    state_next = (shamt_i != '0) ? SHIFT : DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Single-bit step applied once per SHIFT cycle.
    always_comb begin
        shifted = {result[WIDTH-2:0], 1'b0};
        case (mode_q)
            MODE_SLL: shifted = {result[WIDTH-2:0], 1'b0};
            MODE_SRL: shifted = {1'b0, result[WIDTH-1:1]};
            MODE_SRA: shifted = {result[WIDTH-1], result[WIDTH-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
            MODE_ROL: shifted = {result[WIDTH-2:0], result[WIDTH-1]};
`else
            MODE_ROL: shifted = {result[WIDTH-2:0], 1'b0};
`endif
            default:  shifted = {result[WIDTH-2:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result <= '0;
            count  <= '0;
            mode_q <= MODE_SLL;
        end else if (accept) begin
            result <= data_i;
            count  <= shamt_i;
            mode_q <= mode_i;
        end else if (state == SHIFT) begin
            result <= shifted;
            count  <= count - SHAMT_W'(1);
        end
    end

    assign data_o = result;

endmodule

`default_nettype wire

// File: tb/tb_seq_shifter.sv
// ============================================================================
// Module   : tb_seq_shifter
// Purpose  : Directed self-checking bench for seq_shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    int tests;
    int fails;
    int overlap;

    seq_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .start_i (start),
        .data_i  (data),
        .shamt_i (shamt),
        .mode_i  (mode),
        .busy_o  (busy),
        .done_o  (done),
        .data_o  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and count cycles (accepting edge = cycle 0) until done.
    // A nonzero pulse re-asserts start with unrelated operands during that cycle.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                          input int pulse, output int lat, output int bcnt,
                          output logic [31:0] res);
        lat  = -1;
        bcnt = 0;
        res  = 32'hx;
        @(negedge clk);
        start = 1'b1; data = d; shamt = s; mode = m;
        @(negedge clk);
        start = 1'b0; data = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            if (busy && done) overlap++;
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                res = dout;
            end else begin
                start = (c == pulse);
                if (c == pulse) begin
                    data = 32'hFFFF0000; shamt = 5'd3; mode = 2'b01;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    int          lat;
    int          bcnt;
    int          dcnt;
    logic [31:0] res;
    logic [31:0] rol_exp1;
    logic [31:0] rol_exp4;

    initial begin
        tests = 0; fails = 0; overlap = 0;
        rst_n = 1'b0; start = 1'b0; data = '0; shamt = '0; mode = '0;
`ifdef SEQ_SHIFTER_ROTATE_EN
        rol_exp1 = 32'h0000_0003;
        rol_exp4 = 32'h0000_0018;
`else
        rol_exp1 = 32'h0000_0002;
        rol_exp4 = 32'h0000_0010;
`endif
        #3;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_data", dout, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h0000_0001, 5'd2, 2'b00, 0, lat, bcnt, res);
        check("sll_lat", lat, 3);
        check("sll_data", res, 32'h0000_0004);
        check("sll_busy_cycles", bcnt, 2);
        @(negedge clk);
        check("sll_done_one_cycle", {31'd0, done}, 32'd0);
        check("sll_idle_busy", {31'd0, busy}, 32'd0);
        check("sll_data_held", dout, 32'h0000_0004);

        run_op(32'h8000_0000, 5'd4, 2'b10, 0, lat, bcnt, res);
        check("sra_lat", lat, 5);
        check("sra_data", res, 32'hF800_0000);

        run_op(32'h8000_0000, 5'd4, 2'b01, 0, lat, bcnt, res);
        check("srl_data", res, 32'h0800_0000);

        run_op(32'h7F00_0000, 5'd4, 2'b10, 0, lat, bcnt, res);
        check("sra_pos_data", res, 32'h07F0_0000);

        run_op(32'h8000_0001, 5'd1, 2'b11, 0, lat, bcnt, res);
        check("rol1_lat", lat, 2);
        check("rol1_data", res, rol_exp1);

        run_op(32'h8000_0001, 5'd4, 2'b11, 0, lat, bcnt, res);
        check("rol4_data", res, rol_exp4);

        run_op(32'hDEAD_BEEF, 5'd0, 2'b01, 0, lat, bcnt, res);
        check("zero_lat", lat, 1);
        check("zero_data", res, 32'hDEAD_BEEF);
        check("zero_busy_cycles", bcnt, 0);

        run_op(32'h0000_0001, 5'd31, 2'b00, 5, lat, bcnt, res);
        check("ignore_lat", lat, 32);
        check("ignore_data", res, 32'h8000_0000);
        check("ignore_busy_cycles", bcnt, 31);

        // Back-to-back: start held through DONE launches the next op directly.
        @(negedge clk);
        start = 1'b1; data = 32'hA5A5_A5A5; shamt = 5'd0; mode = 2'b00;
        @(negedge clk);
        check("b2b_done1", {31'd0, done}, 32'd1);
        check("b2b_data1", dout, 32'hA5A5_A5A5);
        data = 32'h8000_0000; shamt = 5'd1; mode = 2'b10;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_no_idle", {31'd0, busy}, 32'd1);
        check("b2b_not_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("b2b_done2", {31'd0, done}, 32'd1);
        check("b2b_data2", dout, 32'hC000_0000);

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        start = 1'b1; data = 32'h0000_0001; shamt = 5'd10; mode = 2'b00;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        check("rst_mid_data_before", dout, 32'h0000_0008);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_data", dout, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("rst_no_done_pulse", dcnt, 0);
        check("rst_data_stays", dout, 32'd0);

        run_op(32'h0000_0003, 5'd31, 2'b00, 0, lat, bcnt, res);
        check("post_rst_lat", lat, 32);
        check("post_rst_data", res, 32'h8000_0000);

        check("busy_done_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
